// File: rtl/csrhpm_if.sv
// CSR bus between the CSR unit and the programmable performance monitor.
// The CSR unit drives address and write data; the monitor returns read data and an illegal flag.
interface csrhpm_if #(
   parameter int XLEN = 64
);
   logic            CSRMWriteM;
   logic [11:0]     CSRAdrM;
   logic [XLEN-1:0] CSRWriteValM;
   logic [XLEN-1:0] CSRHPMReadValM;
   logic            IllegalCSRHPMAccessM;

   modport master (
      output CSRMWriteM, CSRAdrM, CSRWriteValM,
      input  CSRHPMReadValM, IllegalCSRHPMAccessM
   );

   modport slave (
      input  CSRMWriteM, CSRAdrM, CSRWriteValM,
      output CSRHPMReadValM, IllegalCSRHPMAccessM
   );
endinterface

// File: rtl/csrhpm.sv
// Programmable hardware performance monitor: mhpmcounter3..N-1 with event
// selectors, per-mode inhibit and Sscofpmf overflow tracking (OF, scountovf, LCOFI).
module csrhpm #(
   parameter int XLEN         = 64,
   parameter int NUM_COUNTERS = 32,
   parameter int NUM_EVENTS   = 64,
   parameter int EVSEL_BITS   = 8
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] EventM,
   input  logic [1:0]            PrivilegeModeM,
   input  logic                  VirtModeM,
   input  logic [31:0]           MCOUNTINHIBIT_REGW,
   input  logic [31:0]           MCOUNTEREN_REGW,
   csrhpm_if.slave               bus,
   output logic                  LCOFISetM
);
   localparam int NC   = NUM_COUNTERS;
   localparam bit RV32 = (XLEN == 32);

   // flags: {OF, MINH, SINH, UINH, VSINH, VUINH}
   logic [63:0]           cnt_q [NC];
   logic [63:0]           cnt_d [NC];
   logic [EVSEL_BITS-1:0] sel_q [NC];
   logic [EVSEL_BITS-1:0] sel_d [NC];
   logic [5:0]            flg_q [NC];
   logic [5:0]            flg_d [NC];
   logic                  lcofi_q, lcofi_d;

   logic [11:0] adr;
   logic [4:0]  idx;
   logic        idx_ok;
   logic        hit_ev, hit_evh, hit_cnt, hit_cnth, hit_ovf;
   logic        wr_ev, wr_evh, wr_cnt, wr_cnth;
   logic [63:0] wv;

   logic [NC-1:0] ev_hit, mode_inh, inc;

   assign adr    = bus.CSRAdrM;
   assign idx    = adr[4:0];
   assign idx_ok = (int'(idx) >= 3) && (int'(idx) < NC);
   assign wv     = 64'(bus.CSRWriteValM);

   // Address decode; counters 0..2 live in the fixed counter block
   always_comb begin
      hit_ev   = (adr[11:5] == 7'b0011001) & idx_ok;
      hit_evh  = (adr[11:5] == 7'b0111001) & idx_ok & RV32;
      hit_cnt  = (adr[11:5] == 7'b1011000) & idx_ok;
      hit_cnth = (adr[11:5] == 7'b1011100) & idx_ok & RV32;
      hit_ovf  = (adr == 12'hDA0) & ~bus.CSRMWriteM &
                 (PrivilegeModeM != 2'b00);
      wr_ev    = bus.CSRMWriteM & hit_ev;
      wr_evh   = bus.CSRMWriteM & hit_evh;
      wr_cnt   = bus.CSRMWriteM & hit_cnt;
      wr_cnth  = bus.CSRMWriteM & hit_cnth;
   end

   // Per-counter increment: selected event, gated by global and mode inhibit
   always_comb begin
      ev_hit   = '0;
      mode_inh = '0;
      inc      = '0;
      for (int i = 0; i < NC; i++) begin
         for (int e = 1; e < NUM_EVENTS; e++)
            if (sel_q[i] == EVSEL_BITS'(e)) ev_hit[i] = EventM[e];
         case (PrivilegeModeM)
            2'b11:   mode_inh[i] = flg_q[i][4];
            2'b01:   mode_inh[i] = VirtModeM ? flg_q[i][1] : flg_q[i][3];
            2'b00:   mode_inh[i] = VirtModeM ? flg_q[i][0] : flg_q[i][2];
            default: mode_inh[i] = 1'b0;
         endcase
         inc[i] = ev_hit[i] & ~MCOUNTINHIBIT_REGW[i] & ~mode_inh[i] &
                  (i >= 3);
      end
   end

   // Next state: CSR writes beat increments and hardware OF set
   always_comb begin
      logic [63:0] sum;
      logic [63:0] evv;
      logic        ovf, cwl, cwh, ewl, ewh;
      sum     = '0;
      evv     = '0;
      ovf     = 1'b0;
      cwl     = 1'b0;
      cwh     = 1'b0;
      ewl     = 1'b0;
      ewh     = 1'b0;
      lcofi_d = 1'b0;
      for (int i = 0; i < NC; i++) begin
         cwl = wr_cnt  & (int'(idx) == i);
         cwh = wr_cnth & (int'(idx) == i);
         ewl = wr_ev   & (int'(idx) == i);
         ewh = wr_evh  & (int'(idx) == i);
         sum = cnt_q[i] + {63'b0, inc[i]};
         ovf = inc[i] & (&cnt_q[i]) & ~cwl & ~cwh;
         cnt_d[i] = sum;
         if (cwl) cnt_d[i] = RV32 ? {sum[63:32], wv[31:0]} : wv;
         if (cwh) cnt_d[i] = {wv[31:0], sum[31:0]};
         evv = {flg_q[i], {(58-EVSEL_BITS){1'b0}}, sel_q[i]};
         if (ewl) evv = RV32 ? {evv[63:32], wv[31:0]} : wv;
         if (ewh) evv = {wv[31:0], evv[31:0]};
         sel_d[i] = sel_q[i];
         flg_d[i] = flg_q[i];
         if (ewl | ewh) begin
            sel_d[i] = evv[EVSEL_BITS-1:0];
            flg_d[i] = evv[63:58];
         end else if (ovf) begin
            flg_d[i][5] = 1'b1;
         end
         lcofi_d = lcofi_d | (ovf & ~flg_q[i][5]);
      end
   end

   // State registers; reset also swallows a pending LCOFI pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NC; i++) begin
            cnt_q[i] <= '0;
            sel_q[i] <= '0;
            flg_q[i] <= '0;
         end
         lcofi_q <= 1'b0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            cnt_q[i] <= cnt_d[i];
            sel_q[i] <= sel_d[i];
            flg_q[i] <= flg_d[i];
         end
         lcofi_q <= lcofi_d;
      end
   end

   assign LCOFISetM = lcofi_q;

   // Combinational read mux; unmatched addresses read 0 and flag illegal
   always_comb begin
      logic [31:0] ovf_vec;
      logic [63:0] rd;
      ovf_vec = '0;
      rd      = '0;
      for (int i = 0; i < NC; i++) begin
         ovf_vec[i] = flg_q[i][5];
         if (int'(idx) == i) begin
            if (hit_ev | hit_evh)
               rd = {flg_q[i], {(58-EVSEL_BITS){1'b0}}, sel_q[i]};
            if (hit_cnt | hit_cnth)
               rd = cnt_q[i];
         end
      end
      if (hit_ovf) begin
         if (PrivilegeModeM == 2'b01)
            rd = {32'b0, ovf_vec & MCOUNTEREN_REGW};
         else
            rd = {32'b0, ovf_vec};
      end
      if (hit_evh | hit_cnth) rd = {32'b0, rd[63:32]};
      bus.CSRHPMReadValM       = XLEN'(rd);
      bus.IllegalCSRHPMAccessM = ~(hit_ev | hit_evh | hit_cnt |
                                   hit_cnth | hit_ovf);
   end
endmodule

// File: doc/csrhpm.md
Name: csrhpm

Overview:
- Programmable hardware performance monitor for the privileged unit.
- Generalises the fixed-mapping counter block:
  - NUM_COUNTERS counters, each 64 bit, with a writable mhpmevent selector choosing any of NUM_EVENTS event inputs.
  - Per-mode count inhibit.
  - Sscofpmf overflow tracking (OF bit, scountovf, LCOFI request).
- Covers mhpmcounter3..N-1 and mhpmevent3..N-1. mcycle/minstret stay in the existing counter block.
- Sits beside that block in the CSR unit; the CSR read mux ORs CSRHPMReadValM into the result.

Parameters:
- XLEN, 64, register width; 32 or 64.
- NUM_COUNTERS, 32, highest counter index + 1; counters 3..NUM_COUNTERS-1 are implemented, 4..32.
- NUM_EVENTS, 64, event input count; event 0 is reserved as "never".
- EVSEL_BITS, 8, width of the event-select field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- EventM  in  NUM_EVENTS  per-cycle event strobes; bit 0 is ignored
- PrivilegeModeM  in  2  current mode: 3=M, 1=S, 0=U
- VirtModeM  in  1  virtualised mode
- MCOUNTINHIBIT_REGW  in  32  bit i freezes counter i
- MCOUNTEREN_REGW  in  32  gates the S-mode scountovf view
- CSRMWriteM  in  1  machine CSR write strobe
- CSRAdrM  in  12  CSR address
- CSRWriteValM  in  XLEN  write data
- CSRHPMReadValM  out  XLEN  read data
- IllegalCSRHPMAccessM  out  1  address unimplemented in this block, or S-mode read not permitted
- LCOFISetM  out  1  one-cycle pulse that sets mip.LCOFIP

Behaviour:
- Event register layout (mhpmevent, 0x323+i-3):
  - bits [EVSEL_BITS-1:0] = SEL.
  - 63 = OF, 62 = MINH, 61 = SINH, 60 = UINH, 59 = VSINH, 58 = VUINH.
  - All other bits read 0.
- RV32 event register split:
  - Low half at 0x323+i-3.
  - Bits 63:32 in mhpmeventh at 0x723+i-3.
- Counter address map:
  - mhpmcounter at 0xB00+i.
  - RV32 high half: mhpmcounterh at 0xB80+i.
- scountovf at 0xDA0:
  - Read-only; bit i = OF of counter i; bits 0-2 are 0.
  - In S mode the value is ANDed with MCOUNTEREN_REGW. In U mode the read is illegal.
  - M/S permission for all other addresses is checked upstream.
- Reset: all counters, all event registers (including OF), and LCOFISetM go to 0.
- Increment condition for counter i: Inc_i = EventM[SEL] & ~MCOUNTINHIBIT_REGW[i] & ~ModeInh_i.
  - SEL >= NUM_EVENTS or SEL == 0 gives no event.
  - ModeInh_i is selected by mode: MINH in M; SINH in S with V=0; UINH in U with V=0; VSINH in S with V=1; VUINH in U with V=1.
- Counter update: counter <= counter + Inc_i, applied at posedge. Full 64-bit wrap.
- Overflow:
  - Occurs when Inc_i=1 and counter == 64'hFFFF_FFFF_FFFF_FFFF. Next value is 0 and OF_i <= 1.
  - If OF_i was 0 before the overflow, LCOFISetM pulses high for exactly one cycle, in the cycle after the wrap.
  - Overflow with OF already set: no pulse.
  - LCOFISetM is the registered OR across all counters.
- OF is sticky; it clears only on a CSR write of 0 to the OF bit.
- Write priority (same cycle):
  - A CSR write to a counter wins over its increment, and that cycle cannot overflow.
  - A CSR write to mhpmevent wins over a hardware OF set on the same counter.
  - RV32: a write to one half replaces that half. The other half takes its incremented value, so a carry into the unwritten high half is kept.
- Reads:
  - Combinational, zero latency. A write becomes visible the cycle after CSRMWriteM.
  - RV32 reads return the selected 32-bit half.
- Illegal access: IllegalCSRHPMAccessM=1 and read value 0 for any of:
  - an address outside the ranges above;
  - a counter index >= NUM_COUNTERS;
  - any write to scountovf;
  - mhpmeventh or mhpmcounterh when XLEN=64.
- Unimplemented counters read 0. Event inputs are sampled only in the current cycle; no buffering.
- Reset mid-overflow: reset wins, and no LCOFISetM pulse is issued.

Test Plan:
- Select and count:
  - Stimulus: write mhpmevent3 SEL=5; hold EventM[5]=1 for 10 cycles while in M mode.
  - Required: mhpmcounter3 reads 10, and every other counter reads 0.
- Mode inhibit:
  - Stimulus: set MINH on counter 4 (SEL=7); pulse EventM[7] 4 cycles in M mode, then 3 cycles in U mode.
  - Required: counter4 reads 3.
- Overflow:
  - Stimulus: write mhpmcounter5 = 64'hFFFF_FFFF_FFFF_FFFE; apply 2 event cycles.
  - Required: counter reads 0; OF5=1; scountovf bit5=1; exactly one LCOFISetM pulse.
  - Stimulus: overflow it a second time.
  - Required: no pulse.
- Write/increment collision:
  - Stimulus: in the same cycle, write counter3 = 100 while its event is active.
  - Required: counter3 reads 100 the next cycle.
  - Stimulus: clear OF via mhpmevent write while a hardware overflow occurs.
  - Required: OF=0 afterwards.
- RV32:
  - Stimulus: write mhpmcounter6 low = 32'hFFFF_FFFF while an event is active; then write mhpmcounterh6 = 32'h12.
  - Required: the carry propagates into the high half, and the final high half reads 32'h12.
- Illegal / S view:
  - Stimulus: read 0xB00+NUM_COUNTERS.
  - Required: IllegalCSRHPMAccessM=1.
  - Stimulus: read scountovf from S mode with MCOUNTEREN=0.
  - Required: 0.
  - Stimulus: read scountovf from U mode.
  - Required: illegal.
